seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider that produces one quotient bit per clock.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start               request a division; accepted on an edge while ready=1
//   dividend, divisor   unsigned operands, captured when start is accepted
//   ready               a start will be accepted (IDLE or DONE)
//   busy                an iteration is in progress (CALC)
//   valid               one-cycle pulse marking new results
//   quotient, remainder results, held until the next valid or reset
//   div_by_zero         the last accepted divisor was zero
module seq_divider #(
    parameter int unsigned DIVIDEND_W = 64,
    parameter int unsigned DIVISOR_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  ready,
    output logic                  busy,
    output logic                  valid,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
    localparam int unsigned REM_W = DIVISOR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]      cnt;
    logic [DIVISOR_W-1:0]  div_r;
    logic [DIVIDEND_W-1:0] q_work;   // dividend bits shift out the top, quotient bits shift in
    logic [REM_W-1:0]      p_rem;    // one spare bit so compare/subtract cannot overflow

    logic [REM_W-1:0]      rem_shift;
    logic                  q_bit;
    logic [REM_W-1:0]      rem_nxt;
    logic [DIVIDEND_W-1:0] q_nxt;
    logic                  accept;
    logic                  last_step;

    assign accept    = ready && start;
    assign last_step = (cnt == CNT_W'(1));

    // One restoring step: shift in the next dividend MSB, subtract when it fits.
    always_comb begin
        rem_shift = (p_rem << 1) | REM_W'(q_work[DIVIDEND_W-1]);
        q_bit     = (rem_shift >= REM_W'(div_r));
        rem_nxt   = q_bit ? (rem_shift - REM_W'(div_r)) : rem_shift;
        q_nxt     = {q_work[DIVIDEND_W-2:0], q_bit};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ready = 1'b1;
        busy  = 1'b0;
        valid = 1'b0;
        case (state)
            CALC: begin
                ready = 1'b0;
                busy  = 1'b1;
            end
            DONE:    valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            div_r       <= '0;
            q_work      <= '0;
            p_rem       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_r  <= divisor;
            q_work <= dividend;
            p_rem  <= '0;
            if (divisor == '0) begin
                // Zero divisor bypasses CALC and publishes a saturated result.
                cnt         <= '0;
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end else begin
                cnt         <= CNT_W'(DIVIDEND_W);
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            p_rem  <= rem_nxt;
            q_work <= q_nxt;
            cnt    <= cnt - CNT_W'(1);
            if (last_step) begin
                quotient  <= q_nxt;
                remainder <= rem_nxt[DIVISOR_W-1:0];
            end
        end
    end

endmodule
